id_ex_dual_pipe: RTL and testbench

Dual-issue ID/EX pipeline register that sits directly downstream of the decode-hazard forwarding stage. It captures both issue slots (decoded control plus forwarded rs1/rs2 data) into the IDEX_* registers consumed by EX and by the decode-stage forwarding/stall logic. It handles flush, EX back-pressure and load-use bubble insertion. It also splits an unsafe ("unicorn") pair into two single-slot issues over two cycles, using a 2-state FSM.

---
 rtl/id_ex_dual_pipe.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_dual_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_dual_pipe.sv
// Dual-issue ID/EX pipeline register with flush, EX back-pressure, load-use bubbles
// and unsafe-pair splitting. Optional perf counters enabled by `define IDEX_PERF_CNT_EN.
module id_ex_dual_pipe #(
    parameter int DATA_WIDTH    = 64,
    parameter int PC_WIDTH      = 64,
    parameter int ALU_OP_WIDTH  = 5,
    parameter int LD_TYPE_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Decode_Valid_0,
    input  logic                     Decode_Valid_1,
    input  logic [PC_WIDTH-1:0]      Decode_Pc_0,
    input  logic [PC_WIDTH-1:0]      Decode_Pc_1,
    input  logic [4:0]               Decode_RdAddr_0,
    input  logic [4:0]               Decode_RdAddr_1,
    input  logic                     Decode_WbRdEn_0,
    input  logic                     Decode_WbRdEn_1,
    input  logic [LD_TYPE_WIDTH-1:0] Decode_LdType_0,
    input  logic [LD_TYPE_WIDTH-1:0] Decode_LdType_1,
    input  logic [ALU_OP_WIDTH-1:0]  Decode_AluOp_0,
    input  logic [ALU_OP_WIDTH-1:0]  Decode_AluOp_1,
    input  logic [DATA_WIDTH-1:0]    Decode_Imm_0,
    input  logic [DATA_WIDTH-1:0]    Decode_Imm_1,
    input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs1Data_0,
    input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs1Data_1,
    input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs2Data_0,
    input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs2Data_1,
    input  logic                     DecodeHazard_StallReq,
    input  logic                     DecodeHazard_Unicorn,
    input  logic                     EX_StallReq,
    input  logic                     EX_Flush,
    output logic                     IDEX_Valid_0,
    output logic                     IDEX_Valid_1,
    output logic [PC_WIDTH-1:0]      IDEX_Pc_0,
    output logic [PC_WIDTH-1:0]      IDEX_Pc_1,
    output logic [4:0]               IDEX_RdAddr_0,
    output logic [4:0]               IDEX_RdAddr_1,
    output logic                     IDEX_WbRdEn_0,
    output logic                     IDEX_WbRdEn_1,
    output logic [LD_TYPE_WIDTH-1:0] IDEX_LdType_0,
    output logic [LD_TYPE_WIDTH-1:0] IDEX_LdType_1,
    output logic [ALU_OP_WIDTH-1:0]  IDEX_AluOp_0,
    output logic [ALU_OP_WIDTH-1:0]  IDEX_AluOp_1,
    output logic [DATA_WIDTH-1:0]    IDEX_Imm_0,
    output logic [DATA_WIDTH-1:0]    IDEX_Imm_1,
    output logic [DATA_WIDTH-1:0]    IDEX_Rs1Data_0,
    output logic [DATA_WIDTH-1:0]    IDEX_Rs1Data_1,
    output logic [DATA_WIDTH-1:0]    IDEX_Rs2Data_0,
    output logic [DATA_WIDTH-1:0]    IDEX_Rs2Data_1,
    output logic                     IDEX_HoldReq,
    output logic [31:0]              IDEX_BubbleCnt,
    output logic [31:0]              IDEX_SplitCnt
);

    localparam logic [LD_TYPE_WIDTH-1:0] LD_XXX = '0;

    typedef enum logic {S_NORM = 1'b0, S_SPLIT = 1'b1} state_t;

    typedef struct packed {
        logic                     valid;
        logic [PC_WIDTH-1:0]      pc;
        logic [4:0]               rd;
        logic                     wb;
        logic [LD_TYPE_WIDTH-1:0] ld;
        logic [ALU_OP_WIDTH-1:0]  alu;
        logic [DATA_WIDTH-1:0]    imm;
        logic [DATA_WIDTH-1:0]    rs1;
        logic [DATA_WIDTH-1:0]    rs2;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, pc: '0, rd: '0, wb: 1'b0, ld: LD_XXX,
                                      alu: '0, imm: '0, rs1: '0, rs2: '0};

    state_t state_q, state_d;
    slot_t  slot0_q, slot0_d, slot1_q, slot1_d;
    slot_t  cap0, cap1;
    logic   split_start;

    assign cap0 = '{valid: Decode_Valid_0, pc: Decode_Pc_0, rd: Decode_RdAddr_0,
                    wb: Decode_WbRdEn_0 & Decode_Valid_0, ld: Decode_LdType_0,
                    alu: Decode_AluOp_0, imm: Decode_Imm_0,
                    rs1: DecodeHazard_Rs1Data_0, rs2: DecodeHazard_Rs2Data_0};
    assign cap1 = '{valid: Decode_Valid_1, pc: Decode_Pc_1, rd: Decode_RdAddr_1,
                    wb: Decode_WbRdEn_1 & Decode_Valid_1, ld: Decode_LdType_1,
                    alu: Decode_AluOp_1, imm: Decode_Imm_1,
                    rs1: DecodeHazard_Rs1Data_1, rs2: DecodeHazard_Rs2Data_1};

    assign split_start = (state_q == S_NORM) & DecodeHazard_Unicorn
                         & Decode_Valid_0 & Decode_Valid_1;

    // IF/ID must keep presenting the pair whenever this edge does not consume it fully
    assign IDEX_HoldReq = rst_n & ~EX_Flush
                          & (EX_StallReq | DecodeHazard_StallReq | split_start);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        state_d = state_q;
        if (EX_Flush) begin
            slot0_d = SLOT_BUBBLE;
            slot1_d = SLOT_BUBBLE;
            state_d = S_NORM;
        end else if (EX_StallReq) begin
            slot0_d = slot0_q;
            slot1_d = slot1_q;
        end else if (DecodeHazard_StallReq) begin
            slot0_d = SLOT_BUBBLE;
            slot1_d = SLOT_BUBBLE;
        end else if (state_q == S_SPLIT) begin
            slot0_d = SLOT_BUBBLE;
            slot1_d = cap1;
            state_d = S_NORM;
        end else if (split_start) begin
            slot0_d = cap0;
            slot1_d = SLOT_BUBBLE;
            state_d = S_SPLIT;
        end else begin
            slot0_d = cap0;
            slot1_d = cap1;
        end
    end

    // ID -> EX stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NORM;
            slot0_q <= SLOT_BUBBLE;
            slot1_q <= SLOT_BUBBLE;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign IDEX_Valid_0   = slot0_q.valid;
    assign IDEX_Pc_0      = slot0_q.pc;
    assign IDEX_RdAddr_0  = slot0_q.rd;
    assign IDEX_WbRdEn_0  = slot0_q.wb;
    assign IDEX_LdType_0  = slot0_q.ld;
    assign IDEX_AluOp_0   = slot0_q.alu;
    assign IDEX_Imm_0     = slot0_q.imm;
    assign IDEX_Rs1Data_0 = slot0_q.rs1;
    assign IDEX_Rs2Data_0 = slot0_q.rs2;
    assign IDEX_Valid_1   = slot1_q.valid;
    assign IDEX_Pc_1      = slot1_q.pc;
    assign IDEX_RdAddr_1  = slot1_q.rd;
    assign IDEX_WbRdEn_1  = slot1_q.wb;
    assign IDEX_LdType_1  = slot1_q.ld;
    assign IDEX_AluOp_1   = slot1_q.alu;
    assign IDEX_Imm_1     = slot1_q.imm;
    assign IDEX_Rs1Data_1 = slot1_q.rs1;
    assign IDEX_Rs2Data_1 = slot1_q.rs2;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, split_cnt_q;
    logic        adv;

    // Only edges that actually advance the pipe (no flush, no EX stall) are counted
    assign adv = ~EX_Flush & ~EX_StallReq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            split_cnt_q  <= '0;
        end else if (adv) begin
            if (DecodeHazard_StallReq) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end else if (split_start) begin
                split_cnt_q <= split_cnt_q + 32'd1;
            end
        end
    end

    assign IDEX_BubbleCnt = bubble_cnt_q;
    assign IDEX_SplitCnt  = split_cnt_q;
`else
    assign IDEX_BubbleCnt = '0;
    assign IDEX_SplitCnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_dual_pipe.sv
// Self-checking bench for id_ex_dual_pipe: directed scenarios plus randomized
// traffic against an issue-level reference model.
module tb_id_ex_dual_pipe;
    localparam int DW = 64;
    localparam int PW = 64;
    localparam int AW = 5;
    localparam int LW = 3;

    typedef struct packed {
        logic          v;
        logic [PW-1:0] pc;
        logic [4:0]    rd;
        logic          wb;
        logic [LW-1:0] ld;
        logic [AW-1:0] alu;
        logic [DW-1:0] imm;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
    } slot_t;

    logic clk, rst_n;
    logic          dv[2];
    logic [PW-1:0] dpc[2];
    logic [4:0]    drd[2];
    logic          dwb[2];
    logic [LW-1:0] dld[2];
    logic [AW-1:0] dalu[2];
    logic [DW-1:0] dimm[2];
    logic [DW-1:0] drs1[2];
    logic [DW-1:0] drs2[2];
    logic dhst, uni, exst, flush;

    logic          ov[2];
    logic [PW-1:0] opc[2];
    logic [4:0]    ord[2];
    logic          owb[2];
    logic [LW-1:0] old[2];
    logic [AW-1:0] oalu[2];
    logic [DW-1:0] oimm[2];
    logic [DW-1:0] ors1[2];
    logic [DW-1:0] ors2[2];
    logic          hold;
    logic [31:0]   bcnt, scnt;

    int checks = 0;
    int errors = 0;

    // Reference model: what each slot holds, whether slot1 of the current pair is still owed
    slot_t       m_slot[2];
    bit          m_owed;
    int unsigned m_bub, m_spl;

    id_ex_dual_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .Decode_Valid_0(dv[0]), .Decode_Valid_1(dv[1]),
        .Decode_Pc_0(dpc[0]), .Decode_Pc_1(dpc[1]),
        .Decode_RdAddr_0(drd[0]), .Decode_RdAddr_1(drd[1]),
        .Decode_WbRdEn_0(dwb[0]), .Decode_WbRdEn_1(dwb[1]),
        .Decode_LdType_0(dld[0]), .Decode_LdType_1(dld[1]),
        .Decode_AluOp_0(dalu[0]), .Decode_AluOp_1(dalu[1]),
        .Decode_Imm_0(dimm[0]), .Decode_Imm_1(dimm[1]),
        .DecodeHazard_Rs1Data_0(drs1[0]), .DecodeHazard_Rs1Data_1(drs1[1]),
        .DecodeHazard_Rs2Data_0(drs2[0]), .DecodeHazard_Rs2Data_1(drs2[1]),
        .DecodeHazard_StallReq(dhst), .DecodeHazard_Unicorn(uni),
        .EX_StallReq(exst), .EX_Flush(flush),
        .IDEX_Valid_0(ov[0]), .IDEX_Valid_1(ov[1]),
        .IDEX_Pc_0(opc[0]), .IDEX_Pc_1(opc[1]),
        .IDEX_RdAddr_0(ord[0]), .IDEX_RdAddr_1(ord[1]),
        .IDEX_WbRdEn_0(owb[0]), .IDEX_WbRdEn_1(owb[1]),
        .IDEX_LdType_0(old[0]), .IDEX_LdType_1(old[1]),
        .IDEX_AluOp_0(oalu[0]), .IDEX_AluOp_1(oalu[1]),
        .IDEX_Imm_0(oimm[0]), .IDEX_Imm_1(oimm[1]),
        .IDEX_Rs1Data_0(ors1[0]), .IDEX_Rs1Data_1(ors1[1]),
        .IDEX_Rs2Data_0(ors2[0]), .IDEX_Rs2Data_1(ors2[1]),
        .IDEX_HoldReq(hold),
        .IDEX_BubbleCnt(bcnt), .IDEX_SplitCnt(scnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic slot_t inp(int i);
        slot_t s;
        s.v = dv[i]; s.pc = dpc[i]; s.rd = drd[i]; s.wb = dwb[i] & dv[i];
        s.ld = dld[i]; s.alu = dalu[i]; s.imm = dimm[i]; s.rs1 = drs1[i]; s.rs2 = drs2[i];
        return s;
    endfunction

    function automatic slot_t obs(int i);
        slot_t s;
        s.v = ov[i]; s.pc = opc[i]; s.rd = ord[i]; s.wb = owb[i];
        s.ld = old[i]; s.alu = oalu[i]; s.imm = oimm[i]; s.rs1 = ors1[i]; s.rs2 = ors2[i];
        return s;
    endfunction

    function automatic logic exp_hold();
        bit pair_unsafe = uni && dv[0] && dv[1] && !m_owed;
        return !flush && (exst || dhst || pair_unsafe);
    endfunction

    function automatic logic [31:0] exp_bcnt();
`ifdef IDEX_PERF_CNT_EN
        return m_bub;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_scnt();
`ifdef IDEX_PERF_CNT_EN
        return m_spl;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_slot[0] = '0; m_slot[1] = '0; m_owed = 0; m_bub = 0; m_spl = 0;
    endtask

    // Decide which instructions issue this edge, then fill slots accordingly
    task automatic model_step();
        bit issue0, issue1, advance;
        advance = !flush && !exst;
        issue0 = 0; issue1 = 0;
        if (flush) m_owed = 0;
        if (advance && dhst) m_bub++;
        if (advance && !dhst) begin
            if (m_owed) begin
                issue1 = 1; m_owed = 0;
            end else if (uni && dv[0] && dv[1]) begin
                issue0 = 1; m_owed = 1; m_spl++;
            end else begin
                issue0 = 1; issue1 = 1;
            end
        end
        if (flush || advance) begin
            m_slot[0] = issue0 ? inp(0) : slot_t'('0);
            m_slot[1] = issue1 ? inp(1) : slot_t'('0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            dv[i] = 0; dpc[i] = '0; drd[i] = '0; dwb[i] = 0; dld[i] = '0;
            dalu[i] = '0; dimm[i] = '0; drs1[i] = '0; drs2[i] = '0;
        end
        dhst = 0; uni = 0; exst = 0; flush = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        exst = 1; dv[0] = 1; dv[1] = 1; uni = 1;
        #1;
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %0b want 0", hold); end
        @(posedge clk); #1;
        checks++;
        if (obs(0) !== slot_t'('0) || obs(1) !== slot_t'('0)) begin
            errors++; $display("FAIL reset_slots: got v0=%0b v1=%0b pc0=%0h ld0=%0d want all 0", ov[0], ov[1], opc[0], old[0]);
        end
        checks++;
        if (bcnt !== 32'd0 || scnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bcnt, scnt);
        end
        clear_inputs();
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_normal();
        clear_inputs();
        dv[0] = 1; drd[0] = 5; drs1[0] = 64'h11; dwb[0] = 1;
        dv[1] = 1; drd[1] = 6; dwb[1] = 1;
        #1;
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL normal_hold: got %0b want 0", hold); end
        tick();
        checks++;
        if (ord[0] !== 5'd5 || ord[1] !== 5'd6 || ors1[0] !== 64'h11 || ov[0] !== 1'b1 || ov[1] !== 1'b1) begin
            errors++; $display("FAIL normal_issue: got rd0=%0d rd1=%0d rs1_0=%0h want 5 6 11", ord[0], ord[1], ors1[0]);
        end
    endtask

    task automatic test_split();
        clear_inputs();
        dv[0] = 1; dv[1] = 1; dpc[0] = 64'h100; dpc[1] = 64'h104; uni = 1;
        #1;
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL split_hold1: got %0b want 1", hold); end
        tick();
        checks++;
        if (ov[0] !== 1'b1 || ov[1] !== 1'b0 || opc[0] !== 64'h100) begin
            errors++; $display("FAIL split_c1: got v0=%0b v1=%0b pc0=%0h want 1 0 100", ov[0], ov[1], opc[0]);
        end
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL split_hold2: got %0b want 0", hold); end
        tick();
        checks++;
        if (ov[0] !== 1'b0 || ov[1] !== 1'b1 || opc[1] !== 64'h104) begin
            errors++; $display("FAIL split_c2: got v0=%0b v1=%0b pc1=%0h want 0 1 104", ov[0], ov[1], opc[1]);
        end
        uni = 0;
        #1;
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL split_hold3: got %0b want 0", hold); end
        checks++;
        if (scnt !== exp_scnt()) begin errors++; $display("FAIL split_cnt: got %0d want %0d", scnt, exp_scnt()); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        dv[0] = 1; dv[1] = 1; dld[0] = 3'd2; dld[1] = 3'd4; dwb[0] = 1; dwb[1] = 1; drd[0] = 7;
        dhst = 1;
        #1;
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL ldu_hold: got %0b want 1", hold); end
        tick();
        checks++;
        if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || old[0] !== 3'd0 || old[1] !== 3'd0 || owb[0] !== 1'b0 || ord[0] !== 5'd0) begin
            errors++; $display("FAIL ldu_bubble: got v=%0b%0b ld=%0d/%0d want 00 0/0", ov[0], ov[1], old[0], old[1]);
        end
        dhst = 0;
        tick();
        checks++;
        if (ov[0] !== 1'b1 || ov[1] !== 1'b1 || old[0] !== 3'd2 || old[1] !== 3'd4 || ord[0] !== 5'd7) begin
            errors++; $display("FAIL ldu_capture: got v=%0b%0b ld=%0d/%0d want 11 2/4", ov[0], ov[1], old[0], old[1]);
        end
        checks++;
        if (bcnt !== exp_bcnt()) begin errors++; $display("FAIL ldu_cnt: got %0d want %0d", bcnt, exp_bcnt()); end
    endtask

    task automatic test_ex_stall();
        clear_inputs();
        dv[0] = 1; dv[1] = 1; dpc[0] = 64'hA0; dpc[1] = 64'hA4; drs1[0] = 64'h55;
        tick();
        exst = 1;
        for (int k = 0; k < 3; k++) begin
            dpc[0] = 64'hB0 + 64'(k); dpc[1] = 64'hC0 + 64'(k); drs1[0] = {$urandom, $urandom};
            dhst = k[0]; uni = 1;
            #1;
            checks++;
            if (hold !== 1'b1) begin errors++; $display("FAIL exst_hold%0d: got %0b want 1", k, hold); end
            tick();
            checks++;
            if (opc[0] !== 64'hA0 || opc[1] !== 64'hA4 || ors1[0] !== 64'h55 || ov[0] !== 1'b1 || ov[1] !== 1'b1) begin
                errors++; $display("FAIL exst_frozen%0d: got pc0=%0h pc1=%0h rs1=%0h want a0 a4 55", k, opc[0], opc[1], ors1[0]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_flush_split();
        clear_inputs();
        dv[0] = 1; dv[1] = 1; uni = 1; dpc[0] = 64'h300; dpc[1] = 64'h304;
        tick();
        flush = 1; dhst = 1; exst = 1;
        #1;
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL flush_hold: got %0b want 0", hold); end
        tick();
        checks++;
        if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || opc[0] !== '0) begin
            errors++; $display("FAIL flush_bubble: got v=%0b%0b pc0=%0h want 00 0", ov[0], ov[1], opc[0]);
        end
        flush = 0; dhst = 0; exst = 0; uni = 0;
        #1;
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL flush_hold2: got %0b want 0", hold); end
        tick();
        checks++;
        if (ov[0] !== 1'b1 || ov[1] !== 1'b1) begin
            errors++; $display("FAIL flush_norm: got v=%0b%0b want 11", ov[0], ov[1]);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        dv[0] = 1; dv[1] = 1; uni = 1; dpc[0] = 64'h1F0; dpc[1] = 64'h200;
        dld[0] = 3'd5; drs1[0] = 64'hDEAD;
        tick();
        #3;
        rst_n = 0;
        #1;
        checks++;
        if (obs(0) !== slot_t'('0) || obs(1) !== slot_t'('0) || hold !== 1'b0) begin
            errors++; $display("FAIL arst_clear: got v0=%0b pc0=%0h ld0=%0d hold=%0b want 0", ov[0], opc[0], old[0], hold);
        end
        checks++;
        if (bcnt !== 32'd0 || scnt !== 32'd0) begin
            errors++; $display("FAIL arst_cnt: got %0d/%0d want 0/0", bcnt, scnt);
        end
        model_reset();
        #2;
        rst_n = 1;
        uni = 0;
        tick();
        checks++;
        if (ov[0] !== 1'b1 || ov[1] !== 1'b1 || opc[1] !== 64'h200) begin
            errors++; $display("FAIL arst_noslot1: got v=%0b%0b pc1=%0h want 11 200", ov[0], ov[1], opc[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                dv[i] = ($urandom_range(0, 7) != 0);
                dpc[i] = {$urandom, $urandom}; drd[i] = 5'($urandom); dwb[i] = 1'($urandom);
                dld[i] = 3'($urandom); dalu[i] = 5'($urandom); dimm[i] = {$urandom, $urandom};
                drs1[i] = {$urandom, $urandom}; drs2[i] = {$urandom, $urandom};
            end
            flush = ($urandom_range(0, 15) == 0);
            exst  = ($urandom_range(0, 7) == 0);
            dhst  = ($urandom_range(0, 7) == 0);
            uni   = ($urandom_range(0, 2) == 0);
            #1;
            checks++;
            if (hold !== exp_hold()) begin errors++; $display("FAIL rnd_hold[%0d]: got %0b want %0b", n, hold, exp_hold()); end
            tick();
            checks++;
            if (obs(0) !== m_slot[0] || obs(1) !== m_slot[1]) begin
                errors++; $display("FAIL rnd_slots[%0d]: got v=%0b%0b pc0=%0h pc1=%0h want v=%0b%0b pc0=%0h pc1=%0h",
                                   n, ov[0], ov[1], opc[0], opc[1], m_slot[0].v, m_slot[1].v, m_slot[0].pc, m_slot[1].pc);
            end
            checks++;
            if (bcnt !== exp_bcnt() || scnt !== exp_scnt()) begin
                errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", n, bcnt, scnt, exp_bcnt(), exp_scnt());
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_normal();
        test_split();
        test_load_use();
        test_ex_stall();
        test_flush_split();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
